uart_cmd_rx: RTL and testbench

Receive-side UART and command decoder for the hx1k board. It sits between the `rx` pin and the LED/command registers of the top level, which currently drives `tx`/LEDs outbound only. It deserialises 8N1 frames into bytes, reports each good byte with a valid pulse and reports bad stop bits as framing errors. It keeps the last received byte as `cmd` and updates a 3-bit LED field from a fixed command range.

---
 rtl/uart_cmd_rx.sv | 135 +++++++++++++
 tb/tb_uart_cmd_rx.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_rx.sv
// Receive-side 8N1 UART with command/LED decoder.
// Bytes are reported with a valid pulse; bad stop bits raise a framing-error pulse.
module uart_cmd_rx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy,
    output logic [7:0] cmd,
    output logic [2:0] leds
);

    localparam int unsigned HALF = CLKS_PER_BIT / 2;
    localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shreg, shreg_n;
    logic          rx_m, rx_s;
    logic          good, bad;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shreg <= shreg_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shreg_n = shreg;
        good    = 1'b0;
        bad     = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    cnt_n   = CNT_HALF;
                    state_n = START;
                end
            end
            START: begin
                if (cnt != '0) begin
                    cnt_n = cnt - CW'(1);
                end else if (rx_s) begin
                    state_n = IDLE;
                end else begin
                    cnt_n   = CNT_FULL;
                    idx_n   = '0;
                    state_n = DATA;
                end
            end
            DATA: begin
                if (cnt != '0) begin
                    cnt_n = cnt - CW'(1);
                end else begin
                    shreg_n = {rx_s, shreg[7:1]};
                    cnt_n   = CNT_FULL;
                    idx_n   = idx + 3'd1;
                    if (idx == 3'd7) state_n = STOP;
                end
            end
            STOP: begin
                if (cnt != '0) begin
                    cnt_n = cnt - CW'(1);
                end else if (rx_s) begin
                    good    = 1'b1;
                    state_n = IDLE;
                end else begin
                    bad     = 1'b1;
                    state_n = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Result registers update in the cycle IDLE is re-entered.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data      <= '0;
            cmd       <= '0;
            leds      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= good;
            frame_err <= bad;
            if (good) begin
                data <= shreg;
                cmd  <= shreg;
                if (shreg[7:3] == 5'b10100) leds <= shreg[2:0];
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx: a per-cycle expectation timeline built from the
// frames the driver sends, compared against the DUT on every falling edge.
module tb_uart_cmd_rx;

    localparam int MAXC = 4096;
    localparam int CPB  = 16;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data, cmd;
    logic       valid, frame_err, busy;
    logic [2:0] leds;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic       exp_valid [MAXC];
    logic       exp_ferr  [MAXC];
    logic       exp_busy  [MAXC];
    logic [7:0] exp_data  [MAXC];
    logic [7:0] exp_cmd   [MAXC];
    logic [2:0] exp_leds  [MAXC];

    int valid_count = 0;
    int ferr_count = 0;
    int last_valid = -1;
    int prev_valid = -1;

    uart_cmd_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .resetn(resetn), .rx(rx), .data(data), .valid(valid),
        .frame_err(frame_err), .busy(busy), .cmd(cmd), .leds(leds)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cyc < MAXC) begin
            check("valid", 32'(valid), 32'(exp_valid[cyc]));
            check("frame_err", 32'(frame_err), 32'(exp_ferr[cyc]));
            check("busy", 32'(busy), 32'(exp_busy[cyc]));
            check("data", 32'(data), 32'(exp_data[cyc]));
            check("cmd", 32'(cmd), 32'(exp_cmd[cyc]));
            check("leds", 32'(leds), 32'(exp_leds[cyc]));
        end else begin
            check("cycle_budget", 32'(cyc), 32'(MAXC - 1));
        end
        if (valid === 1'b1) begin
            valid_count++;
            prev_valid = last_valid;
            last_valid = cyc;
        end
        if (frame_err === 1'b1) ferr_count++;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_busy(input int from, input int upto, input logic v);
        for (int c = from; c <= upto && c < MAXC; c++) exp_busy[c] = v;
    endtask

    // Pin falls just after edge k: rx_s low at k+2, IDLE sees it at k+3,
    // stop sample at k+3+152, result visible after edge k+155.
    task automatic sched_frame(input int k, input logic [7:0] b, input logic stopb);
        int tv;
        tv = k + 3 + CPB / 2 + 9 * CPB;
        if (stopb) begin
            set_busy(k + 3, tv - 1, 1'b1);
            exp_valid[tv] = 1'b1;
            for (int c = tv; c < MAXC; c++) begin
                exp_data[c] = b;
                exp_cmd[c]  = b;
                if (b[7:3] == 5'b10100) exp_leds[c] = b[2:0];
            end
        end else begin
            set_busy(k + 3, MAXC - 1, 1'b1);
            exp_ferr[tv] = 1'b1;
        end
    endtask

    task automatic send(input logic [7:0] b, input logic stopb, output int k);
        k = cyc;
        sched_frame(k, b, stopb);
        rx = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cyc(CPB);
        end
        rx = stopb;
        wait_cyc(CPB);
    endtask

    int k0, k1, kr, h, r;

    initial begin
        for (int c = 0; c < MAXC; c++) begin
            exp_valid[c] = 1'b0; exp_ferr[c] = 1'b0; exp_busy[c] = 1'b0;
            exp_data[c]  = '0;   exp_cmd[c]  = '0;   exp_leds[c] = '0;
        end
        @(posedge clk); #1;
        wait_cyc(4);
        resetn = 1'b1;
        wait_cyc(10);

        send(8'h55, 1'b1, k0);
        check("lat_0x55", 32'(last_valid - k0), 32'd155);
        check("data_0x55", 32'(data), 32'h55);
        check("leds_0x55", 32'(leds), 32'd0);
        wait_cyc(20);

        send(8'hA5, 1'b1, k0);
        check("cmd_0xA5", 32'(cmd), 32'hA5);
        check("leds_0xA5", 32'(leds), 32'b101);
        wait_cyc(20);
        send(8'h3C, 1'b1, k0);
        check("cmd_0x3C", 32'(cmd), 32'h3C);
        check("leds_0x3C", 32'(leds), 32'b101);
        wait_cyc(20);

        // False start: 3 cycles low, dropped at the half-bit sample.
        k0 = cyc;
        set_busy(k0 + 3, k0 + 10, 1'b1);
        rx = 1'b0;
        wait_cyc(3);
        rx = 1'b1;
        wait_cyc(20);
        send(8'h12, 1'b1, k0);
        check("data_0x12", 32'(data), 32'h12);
        wait_cyc(20);

        send(8'h81, 1'b0, k0);
        wait_cyc(40 * CPB);
        h = cyc;
        rx = 1'b1;
        set_busy(h + 3, MAXC - 1, 1'b0);
        wait_cyc(20);
        check("ferr_count", 32'(ferr_count), 32'd1);
        check("data_after_ferr", 32'(data), 32'h12);

        send(8'hA2, 1'b1, k0);
        send(8'hA7, 1'b1, k1);
        check("b2b_gap", 32'(last_valid - prev_valid), 32'd160);
        check("cmd_0xA7", 32'(cmd), 32'hA7);
        check("leds_0xA7", 32'(leds), 32'b111);
        wait_cyc(20);

        // Reset asserted during data bit 4 of a 0x99 frame.
        kr = cyc;
        set_busy(kr + 3, kr + 87, 1'b1);
        rx = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = (8'h99 >> i) & 8'h01;
            wait_cyc(CPB);
        end
        rx = 1'b1;
        wait_cyc(CPB / 2);
        r = cyc;
        for (int c = r; c < MAXC; c++) begin
            exp_valid[c] = 1'b0; exp_ferr[c] = 1'b0; exp_busy[c] = 1'b0;
            exp_data[c]  = '0;   exp_cmd[c]  = '0;   exp_leds[c] = '0;
        end
        resetn = 1'b0;
        #1;
        check("rst_data", 32'(data), 32'd0);
        check("rst_leds", 32'(leds), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        wait_cyc(5);
        resetn = 1'b1;
        wait_cyc(10);
        send(8'h0F, 1'b1, k0);
        check("data_0x0F", 32'(data), 32'h0F);
        check("cmd_0x0F", 32'(cmd), 32'h0F);
        wait_cyc(20);
        check("valid_count", 32'(valid_count), 32'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
